pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register, the common successor for the D/E, E/M and M/W boundaries of the five-stage MIPS core. It carries PC, instruction, a generic control/data payload, GRF write info and the Tnew hazard countdown. It adds valid tracking, bubble insertion (flush), exception-request clearing, exception-code and delay-slot propagation, and an optional Tnew decay while held.

Parameters:
PAYLOAD_W, 96, width of the opaque control/data bundle (e.g. ALUout, RD2, DMop, DatatoReg).
A_W, 5, GRF destination address width.
T_W, 4, Tnew counter width.
EXC_W, 5, exception code width (0 = none).
EXC_ENTRY, 32'h0000_4180, PC value loaded on req.
HOLD_DECAY, 0, 1 = Tnew decrements even when en=0 (multi-cycle stall in a later stage).

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
en  in  1  advance: capture inputs
flush  in  1  insert bubble
req  in  1  exception/interrupt request: clear stage
valid_in  in  1  incoming instruction is real
pc_in  in  32  instruction PC
instr_in  in  32  instruction word
payload_in  in  PAYLOAD_W  control/data bundle
wr_en_in  in  1  GRF write enable
a3_in  in  A_W  GRF destination
tnew_in  in  T_W  cycles until result is produced, as seen at the previous stage
exc_in  in  EXC_W  exception code
bd_in  in  1  instruction sits in a delay slot
valid_out  out  1  stage holds a real instruction
pc_out  out  32  registered PC
instr_out  out  32  registered instruction
payload_out  out  PAYLOAD_W  registered bundle
wr_en_out  out  1  registered GRF write enable
a3_out  out  A_W  registered destination
tnew_out  out  T_W  registered countdown
exc_out  out  EXC_W  registered exception code
bd_out  out  1  registered delay-slot flag
fwd_ok  out  1  combinational: valid_out & wr_en_out & (a3_out!=0) & (tnew_out==0)

Behaviour:
- All state updates on posedge clk. Priority: reset > req > flush > en > hold.
- reset: valid_out=0, pc_out=0, instr_out=0, payload_out=0, wr_en_out=0, a3_out=0, tnew_out=0, exc_out=0, bd_out=0. Every register is reset; none is left X.
- req: same clear as reset, except pc_out=EXC_ENTRY. Applies regardless of en and flush.
- flush (req=0): bubble. pc_out=pc_in, bd_out=bd_in so the macroscopic PC survives. All other fields clear, valid_out=0, wr_en_out=0, tnew_out=0.
- en=1 (no req/flush): capture all inputs. tnew_out = sat_dec(tnew_in), where sat_dec(0)=0, else x-1. Width stays T_W; no wrap below 0.
- If valid_in=0 on capture, force wr_en_out=0, exc_out=0 and valid_out=0. PC, instr and payload are still captured.
- en=0 (hold): all fields keep their values. If HOLD_DECAY=1, tnew_out = sat_dec(tnew_out) each held cycle. If HOLD_DECAY=0, tnew_out is held.
- Latency: one cycle input to output. fwd_ok reflects registered state the same cycle, with no input path.
- Simultaneous flush & en: flush wins, so no instruction is captured.
- Simultaneous req & reset: reset wins, so pc_out=0.
- Release from reset: the first capture occurs at the first edge with en=1 and reset=0.

Decomposition:
- Shared package pipe_pkg: width constants (A_W, T_W, EXC_W), EXC_ENTRY, exception code enum (EXC_NONE=0, EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12), and the sat_dec function.
- One sub-module, tnew_ctr, holds the T_W-bit counter with load/clear/decay control. It keeps the decay/saturation logic isolated and reusable.

Test Plan:
- Reset held 2 cycles after random inputs -> all outputs 0, fwd_ok=0.
- en=1, valid_in=1, pc_in=0x3004, wr_en_in=1, a3_in=8, tnew_in=2 -> next cycle pc_out=0x3004, tnew_out=1, fwd_ok=0; then en=1 with tnew_in=0 -> tnew_out=0, fwd_ok=1.
- flush=1 & en=1, pc_in=0x3010, bd_in=1 -> pc_out=0x3010, bd_out=1, valid_out=0, wr_en_out=0, instr_out=0.
- req=1 & flush=1 with pc_in=0x3020 -> pc_out=0x4180, all other outputs 0; reset=1 & req=1 -> pc_out=0.
- HOLD_DECAY=1: load tnew_in=3, then en=0 for 4 cycles -> tnew_out sequence 2,1,0,0 (saturates), other fields stable. HOLD_DECAY=0 -> tnew_out stays 2.
- valid_in=0, wr_en_in=1, exc_in=4, en=1 -> wr_en_out=0, exc_out=0, valid_out=0, fwd_ok=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: default widths,
// exception entry vector, exception codes and the saturating Tnew decrement.
package pipe_pkg;

  localparam int A_W   = 5;
  localparam int T_W   = 4;
  localparam int EXC_W = 5;

  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

  // Interrupt shares code 0 with "no exception"; the cause register tells them apart.
  typedef enum logic [EXC_W-1:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam exc_code_e EXC_NONE = EXC_INT;

  function automatic logic [31:0] sat_dec(input logic [31:0] x);
    return (x == 32'd0) ? 32'd0 : x - 32'd1;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Bundle of everything crossing one pipeline boundary: control strobes,
// the incoming instruction fields and the registered outgoing fields.
interface pipe_stage_reg_if #(
  parameter int PAYLOAD_W = 96,
  parameter int A_W       = 5,
  parameter int T_W       = 4,
  parameter int EXC_W     = 5
);
  logic                 en;
  logic                 flush;
  logic                 req;
  logic                 valid_in;
  logic [31:0]          pc_in;
  logic [31:0]          instr_in;
  logic [PAYLOAD_W-1:0] payload_in;
  logic                 wr_en_in;
  logic [A_W-1:0]       a3_in;
  logic [T_W-1:0]       tnew_in;
  logic [EXC_W-1:0]     exc_in;
  logic                 bd_in;

  logic                 valid_out;
  logic [31:0]          pc_out;
  logic [31:0]          instr_out;
  logic [PAYLOAD_W-1:0] payload_out;
  logic                 wr_en_out;
  logic [A_W-1:0]       a3_out;
  logic [T_W-1:0]       tnew_out;
  logic [EXC_W-1:0]     exc_out;
  logic                 bd_out;
  logic                 fwd_ok;

  modport master (
    output en, flush, req, valid_in, pc_in, instr_in, payload_in,
           wr_en_in, a3_in, tnew_in, exc_in, bd_in,
    input  valid_out, pc_out, instr_out, payload_out, wr_en_out,
           a3_out, tnew_out, exc_out, bd_out, fwd_ok
  );

  modport slave (
    input  en, flush, req, valid_in, pc_in, instr_in, payload_in,
           wr_en_in, a3_in, tnew_in, exc_in, bd_in,
    output valid_out, pc_out, instr_out, payload_out, wr_en_out,
           a3_out, tnew_out, exc_out, bd_out, fwd_ok
  );

endinterface

// File: rtl/pipe_stage_reg_tnew_ctr.sv
// Tnew hazard countdown: loads a pre-decremented value on capture, clears on
// bubble/exception, and optionally keeps counting down while the stage is held.
module tnew_ctr
  import pipe_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         decay_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (load_i)
      cnt_d = W'(sat_dec(32'(load_val_i)));
    else if (decay_i)
      cnt_d = W'(sat_dec(32'(cnt_q)));
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register (D/E, E/M, M/W) with valid tracking,
// bubble insertion, exception clearing and Tnew countdown.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          PAYLOAD_W  = 96,
  parameter int          A_W        = pipe_pkg::A_W,
  parameter int          T_W        = pipe_pkg::T_W,
  parameter int          EXC_W      = pipe_pkg::EXC_W,
  parameter logic [31:0] EXC_ENTRY  = pipe_pkg::EXC_ENTRY,
  parameter bit          HOLD_DECAY = 1'b0
) (
  input logic              clk,
  input logic              reset,
  pipe_stage_reg_if.slave  stg
);

  logic                 valid_q, valid_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          instr_q, instr_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic                 wr_en_q, wr_en_d;
  logic [A_W-1:0]       a3_q, a3_d;
  logic [EXC_W-1:0]     exc_q, exc_d;
  logic                 bd_q, bd_d;
  logic [T_W-1:0]       tnew_q;

  // Flush keeps PC and delay-slot flag so the EPC of a bubbled slot stays correct.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    payload_d = payload_q;
    wr_en_d   = wr_en_q;
    a3_d      = a3_q;
    exc_d     = exc_q;
    bd_d      = bd_q;
    if (stg.req) begin
      valid_d   = 1'b0;
      pc_d      = EXC_ENTRY;
      instr_d   = '0;
      payload_d = '0;
      wr_en_d   = 1'b0;
      a3_d      = '0;
      exc_d     = '0;
      bd_d      = 1'b0;
    end else if (stg.flush) begin
      valid_d   = 1'b0;
      pc_d      = stg.pc_in;
      instr_d   = '0;
      payload_d = '0;
      wr_en_d   = 1'b0;
      a3_d      = '0;
      exc_d     = '0;
      bd_d      = stg.bd_in;
    end else if (stg.en) begin
      valid_d   = stg.valid_in;
      pc_d      = stg.pc_in;
      instr_d   = stg.instr_in;
      payload_d = stg.payload_in;
      wr_en_d   = stg.wr_en_in & stg.valid_in;
      a3_d      = stg.a3_in;
      exc_d     = stg.valid_in ? stg.exc_in : '0;
      bd_d      = stg.bd_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      instr_q   <= '0;
      payload_q <= '0;
      wr_en_q   <= 1'b0;
      a3_q      <= '0;
      exc_q     <= '0;
      bd_q      <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      payload_q <= payload_d;
      wr_en_q   <= wr_en_d;
      a3_q      <= a3_d;
      exc_q     <= exc_d;
      bd_q      <= bd_d;
    end
  end

  tnew_ctr #(.W(T_W)) u_tnew (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (stg.req | stg.flush),
    .load_i     (stg.en),
    .load_val_i (stg.tnew_in),
    .decay_i    (HOLD_DECAY & ~stg.en),
    .cnt_o      (tnew_q)
  );

  assign stg.valid_out   = valid_q;
  assign stg.pc_out      = pc_q;
  assign stg.instr_out   = instr_q;
  assign stg.payload_out = payload_q;
  assign stg.wr_en_out   = wr_en_q;
  assign stg.a3_out      = a3_q;
  assign stg.tnew_out    = tnew_q;
  assign stg.exc_out     = exc_q;
  assign stg.bd_out      = bd_q;
  assign stg.fwd_ok      = valid_q & wr_en_q & (a3_q != '0) & (tnew_q == '0);

endmodule
